// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle: one-entry output register with status flags.
// master = receiver, slave = consumer.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled majority-vote sampling, configurable
// width/parity/stop bits, one-entry valid/ready output register.
module uart_rx_param #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             rx,
    uart_rx_param_if.master  rx_if
);
    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned MID   = OVERSAMPLE / 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_n;
    logic                 rx_q, rx_s;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [OS_W-1:0]      os_cnt, os_n;
    logic [3:0]           bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, sh_n;
    logic                 par_bit, par_n;
    logic                 fe_acc, fe_n;
    logic [1:0]           smp;
    logic                 vote, at_maj, at_end, done;
    logic                 par_x, pe_now, load;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, pe_q, fe_q, ovr_q;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_q <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_q <= rx;
            rx_s <= rx_q;
        end
    end

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

    // First two votes are latched; the third is live rx_s at the majority point.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            smp <= '0;
        end else if (tick) begin
            if (os_cnt == OS_W'(MID - 1)) smp[0] <= rx_s;
            if (os_cnt == OS_W'(MID))     smp[1] <= rx_s;
        end
    end

    assign at_maj = tick && (os_cnt == OS_W'(MID + 1));
    assign at_end = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));
    assign vote   = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            fe_acc  <= 1'b0;
        end else begin
            state   <= state_n;
            os_cnt  <= os_n;
            bit_cnt <= bit_n;
            shreg   <= sh_n;
            par_bit <= par_n;
            fe_acc  <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        os_n    = os_cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        par_n   = par_bit;
        fe_n    = fe_acc;
        done    = 1'b0;
        if (state != S_IDLE && tick)
            os_n = at_end ? '0 : os_cnt + OS_W'(1);
        case (state)
            S_IDLE: begin
                if (tick && !rx_s) begin
                    state_n = S_START;
                    os_n    = '0;
                    bit_n   = '0;
                    fe_n    = 1'b0;
                end
            end
            S_START: begin
                if (at_maj && vote) state_n = S_IDLE;
                else if (at_end)    state_n = S_DATA;
            end
            S_DATA: begin
                if (at_maj) sh_n = {vote, shreg[DATA_BITS-1:1]};
                if (at_end) begin
                    if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        bit_n   = '0;
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_n = bit_cnt + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (at_maj) par_n = vote;
                if (at_end) state_n = S_STOP;
            end
            S_STOP: begin
                // Complete at the last stop-bit midpoint so the next start edge is not missed.
                if (at_maj) begin
                    if (!vote) fe_n = 1'b1;
                    if (bit_cnt == 4'(STOP_BITS - 1)) begin
                        done    = 1'b1;
                        state_n = S_IDLE;
                    end
                end else if (at_end) begin
                    bit_n = bit_cnt + 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign par_x  = (^shreg) ^ par_bit;
    assign pe_now = (PARITY == 1) ? par_x : (PARITY == 2) ? ~par_x : 1'b0;
    assign load   = done && (!valid_q || rx_if.rx_ready);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= done && !load;
            if (load) begin
                data_q  <= shreg;
                pe_q    <= pe_now;
                fe_q    <= fe_n;
                valid_q <= 1'b1;
            end else if (valid_q && rx_if.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data    = data_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.parity_err = pe_q;
    assign rx_if.frame_err  = fe_q;
    assign rx_if.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations (8N1, 8E1, 7O2) at 115200 baud.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int BIT_CLK = 432;  // 27 * 16 clocks per bit

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(8)) if1 ();
    uart_rx_param_if #(.DATA_BITS(7)) if2 ();

    uart_rx_param #(.CLK_FREQ(50000000), .BAUD(115200), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut0 (.CLOCK_50(clk), .rst_n(rst_n), .rx(rx0), .rx_if(if0));
    uart_rx_param #(.CLK_FREQ(50000000), .BAUD(115200), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        dut1 (.CLOCK_50(clk), .rst_n(rst_n), .rx(rx1), .rx_if(if1));
    uart_rx_param #(.CLK_FREQ(50000000), .BAUD(115200), .OVERSAMPLE(16),
                    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
        uut2 (.CLOCK_50(clk), .rst_n(rst_n), .rx(rx2), .rx_if(if2));

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cap_cnt [3] = '{0, 0, 0};
    int ovr_cnt [3] = '{0, 0, 0};
    logic [8:0] cap_data [3];
    logic       cap_pe [3];
    logic       cap_fe [3];

    // Record every accepted frame and every overrun pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (if0.rx_valid && if0.rx_ready) begin
            cap_cnt[0]++; cap_data[0] = {1'b0, if0.rx_data};
            cap_pe[0] = if0.parity_err; cap_fe[0] = if0.frame_err;
        end
        if (if1.rx_valid && if1.rx_ready) begin
            cap_cnt[1]++; cap_data[1] = {1'b0, if1.rx_data};
            cap_pe[1] = if1.parity_err; cap_fe[1] = if1.frame_err;
        end
        if (if2.rx_valid && if2.rx_ready) begin
            cap_cnt[2]++; cap_data[2] = {2'b0, if2.rx_data};
            cap_pe[2] = if2.parity_err; cap_fe[2] = if2.frame_err;
        end
        if (if0.overrun) ovr_cnt[0]++;
        if (if1.overrun) ovr_cnt[1]++;
        if (if2.overrun) ovr_cnt[2]++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input int d, input logic v);
        case (d)
            0: rx0 = v;
            1: rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic drive_bit(input int d, input logic v);
        set_rx(d, v);
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int d, input logic [8:0] data, input logic par_bit,
                              input logic stop_low, input int idle_bits);
        int nb;
        int nst;
        nb  = (d == 2) ? 7 : 8;
        nst = (d == 2) ? 2 : 1;
        drive_bit(d, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d, data[i]);
        if (d != 0) drive_bit(d, par_bit);
        for (int s = 0; s < nst; s++) drive_bit(d, !(stop_low && s == 0));
        for (int k = 0; k < idle_bits; k++) drive_bit(d, 1'b1);
    endtask

    typedef struct {
        int         dut;
        logic [8:0] data;
        logic       par_bit;
        logic       stop_low;
        logic [8:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vecs [8];
    int   base, obase;

    initial begin
        vecs[0] = '{0, 9'h0A5, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{1, 9'h007, 1'b1, 1'b0, 9'h007, 1'b0, 1'b0};
        vecs[2] = '{1, 9'h007, 1'b0, 1'b0, 9'h007, 1'b1, 1'b0};
        vecs[3] = '{0, 9'h03C, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b1};
        vecs[4] = '{0, 9'h055, 1'b0, 1'b0, 9'h055, 1'b0, 1'b0};
        vecs[5] = '{2, 9'h05A, 1'b1, 1'b0, 9'h05A, 1'b0, 1'b0};
        vecs[6] = '{2, 9'h05A, 1'b0, 1'b0, 9'h05A, 1'b1, 1'b0};
        vecs[7] = '{2, 9'h001, 1'b0, 1'b1, 9'h001, 1'b0, 1'b1};

        if0.rx_ready = 1'b1;
        if1.rx_ready = 1'b1;
        if2.rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid0", {31'b0, if0.rx_valid}, 0);
        check("rst_data0", {24'b0, if0.rx_data}, 0);
        check("rst_pe0", {31'b0, if0.parity_err}, 0);
        check("rst_fe0", {31'b0, if0.frame_err}, 0);
        check("rst_ovr0", {31'b0, if0.overrun}, 0);
        check("rst_valid2", {31'b0, if2.rx_valid}, 0);
        rst_n = 1'b1;
        repeat (BIT_CLK) @(posedge clk);
        #1;

        // Short low glitch while idle must be rejected silently.
        base = cap_cnt[0];
        set_rx(0, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        set_rx(0, 1'b1);
        repeat (900) @(posedge clk);
        #1;
        check("glitch_cnt", cap_cnt[0] - base, 0);
        check("glitch_valid", {31'b0, if0.rx_valid}, 0);
        check("glitch_pe", {31'b0, if0.parity_err}, 0);
        check("glitch_fe", {31'b0, if0.frame_err}, 0);

        for (int v = 0; v < 8; v++) begin
            base = cap_cnt[vecs[v].dut];
            send_frame(vecs[v].dut, vecs[v].data, vecs[v].par_bit, vecs[v].stop_low, 1);
            check($sformatf("vec%0d_cnt", v), cap_cnt[vecs[v].dut] - base, 1);
            check($sformatf("vec%0d_data", v), {23'b0, cap_data[vecs[v].dut]}, {23'b0, vecs[v].exp_data});
            check($sformatf("vec%0d_pe", v), {31'b0, cap_pe[vecs[v].dut]}, {31'b0, vecs[v].exp_pe});
            check($sformatf("vec%0d_fe", v), {31'b0, cap_fe[vecs[v].dut]}, {31'b0, vecs[v].exp_fe});
        end

        // Overrun: consumer stalled across two back-to-back frames.
        if0.rx_ready = 1'b0;
        base  = cap_cnt[0];
        obase = ovr_cnt[0];
        send_frame(0, 9'h011, 1'b0, 1'b0, 0);
        send_frame(0, 9'h022, 1'b0, 1'b0, 1);
        check("ovr_valid", {31'b0, if0.rx_valid}, 1);
        check("ovr_data", {24'b0, if0.rx_data}, 32'h11);
        check("ovr_pulses", ovr_cnt[0] - obase, 1);
        check("ovr_cnt", cap_cnt[0] - base, 0);
        if0.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_drain_valid", {31'b0, if0.rx_valid}, 0);
        check("ovr_drain_cnt", cap_cnt[0] - base, 1);
        check("ovr_drain_data", {23'b0, cap_data[0]}, 32'h11);

        // Reset in the middle of the data bits abandons the frame.
        base = cap_cnt[0];
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_valid", {31'b0, if0.rx_valid}, 0);
        check("midrst_data", {24'b0, if0.rx_data}, 0);
        rst_n = 1'b1;
        set_rx(0, 1'b1);
        repeat (2 * BIT_CLK) @(posedge clk);
        #1;
        check("midrst_cnt", cap_cnt[0] - base, 0);
        send_frame(0, 9'h081, 1'b0, 1'b0, 1);
        check("post_rst_cnt", cap_cnt[0] - base, 1);
        check("post_rst_data", {23'b0, cap_data[0]}, 32'h81);
        check("post_rst_pe", {31'b0, cap_pe[0]}, 0);
        check("post_rst_fe", {31'b0, cap_fe[0]}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
